// File: rtl/obstacle_ctrl_multi.sv
// Multi-slot obstacle controller: scrolls N_OBS obstacles left, spawns new ones
// after an LFSR-randomised gap, and keeps the score and the score-driven speed.
module obstacle_ctrl_multi #(
    parameter int          N_OBS      = 4,
    parameter int          X_W        = 10,
    parameter int          SCREEN_W   = 640,
    parameter int          TYPE_W     = 3,
    parameter int          SCORE_W    = 16,
    parameter int          SCORE_DIV  = 8,
    parameter int          SPEED_INIT = 2,
    parameter int          SPEED_MAX  = 8,
    parameter int          SPEED_STEP = 100,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               game_tick,
    input  logic                               over,
    input  logic [8:0]                         min_gap,
    output logic [N_OBS*(1+TYPE_W+X_W)-1:0]    obstacles,
    output logic [SCORE_W-1:0]                 score,
    output logic [3:0]                         speed
);

    localparam int W      = 1 + TYPE_W + X_W;
    localparam int TICK_W = $clog2(SCORE_DIV + 1);
    localparam int STEP_W = $clog2(SPEED_STEP + 1);
    localparam int GAP_W  = 10;

    logic [N_OBS-1:0]  valid;
    logic [TYPE_W-1:0] kind [N_OBS];
    logic [X_W-1:0]    xpos [N_OBS];
    logic [TICK_W-1:0] tick_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [N_OBS-1:0]  spawn_sel;
    logic [X_W-1:0]    speed_x;
    logic              step;
    logic              spawn_go;
    logic              score_inc;

    // Galois form of x^16+x^14+x^13+x^11, shifting right.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign step      = game_tick & ~over;
    // One-hot of the lowest clear bit of valid, i.e. the lowest free slot.
    assign spawn_sel = ~valid & (valid + N_OBS'(1));
    assign spawn_go  = step && (gap_cnt == '0) && (|(~valid));
    assign score_inc = step && (tick_cnt == TICK_W'(SCORE_DIV - 1)) && (score != '1);
    assign speed_x   = X_W'(speed);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            for (int i = 0; i < N_OBS; i++) begin
                kind[i] <= '0;
                xpos[i] <= '0;
            end
            score    <= '0;
            speed    <= 4'(SPEED_INIT);
            tick_cnt <= '0;
            step_cnt <= '0;
            gap_cnt  <= {1'b0, min_gap};
            lfsr     <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
            if (step) begin
                // Spawn only targets a slot that was free before this tick, so it
                // never collides with a slot retiring in the same step.
                for (int i = 0; i < N_OBS; i++) begin
                    if (spawn_go && spawn_sel[i]) begin
                        valid[i] <= 1'b1;
                        kind[i]  <= lfsr[TYPE_W-1:0];
                        xpos[i]  <= X_W'(SCREEN_W - 1);
                    end else if (valid[i]) begin
                        if (xpos[i] >= speed_x)
                            xpos[i] <= xpos[i] - speed_x;
                        else
                            valid[i] <= 1'b0;
                    end
                end

                if (gap_cnt != '0)
                    gap_cnt <= gap_cnt - GAP_W'(1);
                else if (spawn_go)
                    gap_cnt <= {1'b0, min_gap} + {5'b00000, lfsr[12:8]};

                if (tick_cnt == TICK_W'(SCORE_DIV - 1))
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + TICK_W'(1);

                // step_cnt tracks score modulo SPEED_STEP without a divider.
                if (score_inc) begin
                    score <= score + SCORE_W'(1);
                    if (step_cnt == STEP_W'(SPEED_STEP - 1)) begin
                        step_cnt <= '0;
                        if (speed < 4'(SPEED_MAX))
                            speed <= speed + 4'd1;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        obstacles = '0;
        for (int i = 0; i < N_OBS; i++)
            obstacles[i*W +: W] = {valid[i], kind[i], xpos[i]};
    end

endmodule

// File: tb/tb_obstacle_ctrl_multi.sv
// Directed bench for obstacle_ctrl_multi: four instances cover the default
// configuration, single-slot retire/respawn, two-slot deferral and score saturation.
module tb_obstacle_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        over = 1'b0;
    logic        tick_a = 1'b0, tick_b = 1'b0, tick_c = 1'b0, tick_d = 1'b0;
    logic [8:0]  mg_a = 9'd10, mg_0 = 9'd0;
    logic [55:0] obs_a, obs_d;
    logic [13:0] obs_b;
    logic [27:0] obs_c;
    logic [15:0] score_a, score_b, score_c;
    logic [3:0]  score_d;
    logic [3:0]  speed_a, speed_b, speed_c, speed_d;
    logic [15:0] lfsr_model;
    logic [15:0] cap, c1, c2;
    int          checks = 0;
    int          errors = 0;
    int          g1, s;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) lfsr_model <= 16'hACE1;
        else     lfsr_model <= {1'b0, lfsr_model[15:1]} ^ (lfsr_model[0] ? 16'hB400 : 16'h0000);
    end

    obstacle_ctrl_multi u_a (
        .clk(clk), .rst(rst), .game_tick(tick_a), .over(over), .min_gap(mg_a),
        .obstacles(obs_a), .score(score_a), .speed(speed_a));

    obstacle_ctrl_multi #(.N_OBS(1)) u_b (
        .clk(clk), .rst(rst), .game_tick(tick_b), .over(over), .min_gap(mg_0),
        .obstacles(obs_b), .score(score_b), .speed(speed_b));

    obstacle_ctrl_multi #(.N_OBS(2)) u_c (
        .clk(clk), .rst(rst), .game_tick(tick_c), .over(over), .min_gap(mg_0),
        .obstacles(obs_c), .score(score_c), .speed(speed_c));

    obstacle_ctrl_multi #(.SCORE_W(4), .SCORE_DIV(1), .SPEED_STEP(5), .SPEED_MAX(4)) u_d (
        .clk(clk), .rst(rst), .game_tick(tick_d), .over(over), .min_gap(mg_0),
        .obstacles(obs_d), .score(score_d), .speed(speed_d));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Holds the chosen instance's game_tick high for n consecutive clocks; cap
    // records the LFSR value the first of those ticks will use.
    task automatic applyStimulus(input int which, input int n);
        @(negedge clk);
        cap = lfsr_model;
        case (which)
            0: tick_a = 1'b1;
            1: tick_b = 1'b1;
            2: tick_c = 1'b1;
            default: tick_d = 1'b1;
        endcase
        repeat (n) @(negedge clk);
        tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0; tick_d = 1'b0;
    endtask

    initial begin
        logic [2:0] ta;
        ta = 3'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_obs", obs_a, 64'd0);
        checkOutput("rst_score", score_a, 64'd0);
        checkOutput("rst_speed", speed_a, 64'd2);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("idle_obs", obs_a, 64'd0);
        checkOutput("idle_score", score_a, 64'd0);
        checkOutput("idle_speed", speed_a, 64'd2);

        for (int k = 1; k <= 13; k++) begin
            applyStimulus(0, 1);
            repeat (2) @(negedge clk);
            if (k == 7)  checkOutput("score_t7", score_a, 64'd0);
            if (k == 8)  checkOutput("score_t8", score_a, 64'd1);
            if (k == 10) checkOutput("nospawn_t10", obs_a, 64'd0);
            if (k == 11) begin
                ta = cap[2:0];
                checkOutput("spawn_t11", obs_a, {42'd0, 1'b1, ta, 10'd639});
            end
            if (k == 12) checkOutput("move_t12", obs_a, {42'd0, 1'b1, ta, 10'd637});
            if (k == 13) checkOutput("move_t13", obs_a, {42'd0, 1'b1, ta, 10'd635});
        end

        over = 1'b1;
        applyStimulus(0, 20);
        checkOutput("over_obs", obs_a, {42'd0, 1'b1, ta, 10'd635});
        checkOutput("over_score", score_a, 64'd1);
        checkOutput("over_speed", speed_a, 64'd2);
        over = 1'b0;

        applyStimulus(0, 799 - 13);
        checkOutput("score_799", score_a, 64'd99);
        checkOutput("speed_799", speed_a, 64'd2);
        applyStimulus(0, 1);
        checkOutput("score_800", score_a, 64'd100);
        checkOutput("speed_800", speed_a, 64'd3);
        applyStimulus(0, 3999);
        checkOutput("speed_4799", speed_a, 64'd7);
        applyStimulus(0, 1);
        checkOutput("speed_4800", speed_a, 64'd8);
        applyStimulus(0, 800);
        checkOutput("score_5600", score_a, 64'd700);
        checkOutput("speed_cap", speed_a, 64'd8);

        applyStimulus(1, 1);
        c1 = cap;
        checkOutput("b_spawn", obs_b, {1'b1, c1[2:0], 10'd639});
        applyStimulus(1, 319);
        checkOutput("b_x1", obs_b, {1'b1, c1[2:0], 10'd1});
        applyStimulus(1, 1);
        checkOutput("b_retire", obs_b, {1'b0, c1[2:0], 10'd1});
        applyStimulus(1, 1);
        checkOutput("b_respawn", obs_b, {1'b1, cap[2:0], 10'd639});

        applyStimulus(2, 1);
        c1 = cap;
        g1 = int'(c1[12:8]);
        s  = g1 + 2;
        checkOutput("c_spawn0", obs_c, {14'd0, 1'b1, c1[2:0], 10'd639});
        applyStimulus(2, g1);
        checkOutput("c_gap_wait", obs_c[27], 64'd0);
        applyStimulus(2, 1);
        c2 = cap;
        checkOutput("c_spawn1", obs_c[27:14], {1'b1, c2[2:0], 10'd639});
        checkOutput("c_move0", obs_c[9:0], 64'(639 - 2 * (g1 + 1)));
        applyStimulus(2, 320 - s);
        checkOutput("c_x1", obs_c[13:0], {1'b1, c1[2:0], 10'd1});
        applyStimulus(2, 1);
        checkOutput("c_retire0", obs_c[13], 64'd0);
        checkOutput("c_slot1", obs_c[27:14], {1'b1, c2[2:0], 10'(639 - 2 * (321 - s))});
        applyStimulus(2, 1);
        checkOutput("c_refill0", obs_c[13:0], {1'b1, cap[2:0], 10'd639});

        applyStimulus(3, 4);
        checkOutput("d_score4", score_d, 64'd4);
        checkOutput("d_speed4", speed_d, 64'd2);
        applyStimulus(3, 1);
        checkOutput("d_speed5", speed_d, 64'd3);
        applyStimulus(3, 5);
        checkOutput("d_speed10", speed_d, 64'd4);
        applyStimulus(3, 5);
        checkOutput("d_score15", score_d, 64'd15);
        applyStimulus(3, 5);
        checkOutput("d_sat", score_d, 64'd15);
        checkOutput("d_speedcap", speed_d, 64'd4);

        @(negedge clk);
        rst = 1'b1;
        tick_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick_a = 1'b0;
        checkOutput("midrst_obs", obs_a, 64'd0);
        checkOutput("midrst_score", score_a, 64'd0);
        checkOutput("midrst_speed", speed_a, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_ctrl_multi.md
Name: obstacle_ctrl_multi

Overview:
Parametrised successor to the game's obstacle controller. Manages N_OBS independent obstacle slots that scroll left at a speed that ramps up with score, spawns new obstacles using an LFSR-randomised gap, and keeps the running score. Sits between the game FSM (over/tick) and the VGA renderer / collision checker, which consume the packed obstacle bus. Single clock domain: the former game clock becomes a one-cycle tick enable.

Parameters:
N_OBS, 4, number of obstacle slots (1..8)
X_W, 10, x-coordinate width
SCREEN_W, 640, spawn x = SCREEN_W-1 (must be < 2**X_W)
TYPE_W, 3, obstacle type width (sprite select)
SCORE_W, 16, score width
SCORE_DIV, 8, game ticks per score point
SPEED_INIT, 2, initial pixels per tick
SPEED_MAX, 8, speed ceiling
SPEED_STEP, 100, score points per speed increment
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
game_tick  in  1  one-clk pulse per game frame step
over  in  1  game over; freezes all state while high
min_gap  in  9  minimum spawn gap in ticks
obstacles  out  N_OBS*(1+TYPE_W+X_W)  slot i at bits [i*W +: W]; each slot = {valid, type, x}
score  out  SCORE_W  score, binary
speed  out  4  current pixels per tick

Behaviour:
- Reset (synchronous on rst=1 at clk edge; overrides everything, including mid-tick): all slots valid=0, type=0, x=0; score=0; speed=SPEED_INIT; tick_cnt=0; gap_cnt=min_gap; lfsr=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clk when rst=0, including while over=1.
- over=1: slots, score, speed, counters hold. game_tick is ignored.
- All updates below occur only on a clk edge with game_tick=1, over=0, rst=0. Outputs are registered and visible one clk after the tick cycle.
- Move: each valid slot with x >= speed: x <= x - speed. If x < speed: valid <= 0 (retire); type and x hold their old values.
- Spawn: if gap_cnt != 0, decrement it. If gap_cnt == 0 and a slot is free, fill the lowest-index free slot with valid=1, type=lfsr[TYPE_W-1:0], x=SCREEN_W-1, and reload gap_cnt = min_gap + lfsr[12:8] (zero-extended).
  - "Free" is evaluated on slot state before this tick. A slot retiring on this tick cannot be refilled until the next tick.
  - All slots full with gap_cnt == 0: gap_cnt stays 0 and the spawn is deferred to the first tick with a free slot.
  - min_gap is sampled at reload time only.
- Score: tick_cnt counts 0..SCORE_DIV-1 and wraps. On the wrap tick, score increments and saturates at all-ones; it does not wrap.
- Speed: when score increments to a nonzero multiple of SPEED_STEP, speed <= min(speed+1, SPEED_MAX).
- Back-to-back game_tick pulses (consecutive clks) are legal; each one is a full step.
- rst asserted together with game_tick: reset wins.

Test Plan:
- Reset: rst=1 for 3 clks, min_gap=10 -> obstacles all 0, score=0, speed=2; after rst drops with no ticks, outputs stay unchanged for 50 clks.
- First spawn and move: min_gap=10, tick every 4 clks -> on tick 11, slot0 valid with x=639. One tick later x=637, then 635 on the following tick. Type equals the lfsr low bits captured at the spawn tick.
- Retire and no same-tick reuse: N_OBS=1, min_gap=0, force slot0 x=1 -> on the next tick slot0 valid=0 and nothing spawns; on the tick after that, slot0 respawns at x=639.
- Full deferral: N_OBS=2, min_gap=0 -> both slots fill on consecutive gap expiries. While both are valid, gap_cnt stays 0. The first free slot is refilled on the tick after it retires.
- Score/speed ramp: SCORE_DIV=8, SPEED_STEP=100 -> score=1 after 8 ticks. At score=100, speed goes from 2 to 3. Speed caps at 8 and never exceeds it. A forced score of 16'hFFFF stays at FFFF.
- Over freeze and mid-run reset: assert over for 20 ticks -> obstacles, score and speed unchanged. Then pulse rst together with game_tick -> all outputs return to reset values on the next clk.
